// File: rtl/lzc_seq_pkg.sv
// Shared types and constants for the sequential byte-wise leading-zero counter.
package lzc_seq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int LZC_BYTE_ALLZERO = 8;

  // Count must represent 0..w inclusive, hence one bit beyond $clog2(w).
  function automatic int cnt_width(input int w);
    return $clog2(w) + 1;
  endfunction

endpackage

// File: rtl/lzc_byte.sv
// Combinational leading-zero count of one byte; 8 means the byte is all zeros.
module lzc_byte
  import lzc_seq_pkg::*;
(
  input  logic [7:0] din,
  output logic [3:0] lz
);

  // Later iterations override earlier ones, so the highest set bit wins.
  always_comb begin
    lz = 4'(LZC_BYTE_ALLZERO);
    for (int i = 0; i < 8; i++) begin
      if (din[i]) lz = 4'(7 - i);
    end
  end

endmodule

// File: rtl/lzc_seq_64.sv
// Multi-cycle leading-zero counter and normalizer: one byte per cycle, MSB byte
// first, sharing a single 8-bit LZC across the whole operand.
//
// state | meaning
// IDLE  | ready for a new operand
// SCAN  | examining byte idx of the captured operand
// DONE  | result held until the consumer takes it
module lzc_seq_64
  import lzc_seq_pkg::*;
#(
  parameter int WIDTH = 64
) (
  input  logic                          CLK,
  input  logic                          RESET_n,
  input  logic                          abort,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [WIDTH-1:0]              in_data,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [cnt_width(WIDTH)-1:0]   out_count,
  output logic                          out_zero,
  output logic [WIDTH-1:0]              out_norm,
  output logic                          busy
);

  localparam int NB = WIDTH / 8;
  localparam int CW = cnt_width(WIDTH);
  localparam int IW = (NB > 1) ? $clog2(NB) : 1;

  state_t           state;
  logic [WIDTH-1:0] opnd;
  logic [IW-1:0]    idx;
  logic [7:0]       cur_byte;
  logic [3:0]       lz;
  logic [CW-1:0]    count_next;
  logic [WIDTH-1:0] norm_next;

  always_comb begin
    cur_byte = '0;
    for (int i = 0; i < NB; i++) begin
      if (idx == IW'(i)) cur_byte = opnd[8*(NB-1-i) +: 8];
    end
  end

  lzc_byte u_lzc_byte (
    .din (cur_byte),
    .lz  (lz)
  );

  // {idx,3'b0} has $clog2(WIDTH) bits, so widening to CW before the add never overflows.
  assign count_next = CW'({idx, 3'b000}) + CW'(lz);
  assign norm_next  = opnd << count_next;

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);

  always_ff @(posedge CLK or negedge RESET_n) begin
    if (!RESET_n) begin
      state     <= IDLE;
      opnd      <= '0;
      idx       <= '0;
      out_count <= '0;
      out_zero  <= 1'b0;
      out_norm  <= '0;
    end else if (abort) begin
      state     <= IDLE;
      idx       <= '0;
      out_count <= '0;
      out_zero  <= 1'b0;
      out_norm  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            opnd  <= in_data;
            idx   <= '0;
            state <= SCAN;
          end
        end
        SCAN: begin
          if (lz != 4'(LZC_BYTE_ALLZERO)) begin
            out_count <= count_next;
            out_zero  <= 1'b0;
            out_norm  <= norm_next;
            state     <= DONE;
          end else if (idx == IW'(NB - 1)) begin
            out_count <= CW'(WIDTH);
            out_zero  <= 1'b1;
            out_norm  <= '0;
            state     <= DONE;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        DONE: begin
          if (out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lzc_seq_64.sv
// Directed self-checking bench for lzc_seq_64 with a bit-level reference model.
module tb_lzc_seq_64;

  logic        CLK;
  logic        RESET_n;
  logic        abort;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [6:0]  out_count;
  logic        out_zero;
  logic [63:0] out_norm;
  logic        busy;

  int n_checks = 0;
  int n_errors = 0;
  logic [63:0] exp_opnd = '0;

  lzc_seq_64 #(.WIDTH(64)) dut (
    .CLK       (CLK),
    .RESET_n   (RESET_n),
    .abort     (abort),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_count (out_count),
    .out_zero  (out_zero),
    .out_norm  (out_norm),
    .busy      (busy)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Reference: walk bits from the MSB, counting zeros until the first one.
  function automatic int model_lz(input logic [63:0] d);
    int n = 0;
    for (int i = 63; i >= 0 && !d[i]; i--) n++;
    return n;
  endfunction

  function automatic logic [63:0] model_norm(input logic [63:0] d);
    return (d == 64'd0) ? 64'd0 : (d << model_lz(d));
  endfunction

  // Bytes examined before a decision is reached.
  function automatic int model_k(input logic [63:0] d);
    return (d == 64'd0) ? 8 : (model_lz(d) / 8 + 1);
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(posedge CLK) begin
    if (RESET_n && !abort && in_valid && in_ready) exp_opnd = in_data;
  end

  always @(negedge CLK) begin
    if (RESET_n) begin
      if (out_valid) begin
        check("cmp_count", 64'(out_count), 64'(model_lz(exp_opnd)));
        check("cmp_zero",  64'(out_zero),  64'(exp_opnd == 64'd0));
        check("cmp_norm",  out_norm,       model_norm(exp_opnd));
      end
      check("cmp_ready_busy", 64'(in_ready), 64'(!busy));
      check("cmp_ready_valid_excl", 64'(in_ready & out_valid), 64'd0);
    end
  end

  task automatic check_reset_outputs(input string tag);
    check({tag, "_in_ready"},  64'(in_ready),  64'd1);
    check({tag, "_out_valid"}, 64'(out_valid), 64'd0);
    check({tag, "_out_count"}, 64'(out_count), 64'd0);
    check({tag, "_out_zero"},  64'(out_zero),  64'd0);
    check({tag, "_out_norm"},  out_norm,       64'd0);
    check({tag, "_busy"},      64'(busy),      64'd0);
  endtask

  // Returns at the negedge right after the accept edge.
  task automatic accept(input logic [63:0] d);
    @(negedge CLK);
    check("accept_ready", 64'(in_ready), 64'd1);
    in_valid = 1'b1;
    in_data  = d;
    @(posedge CLK);
    @(negedge CLK);
    in_valid = 1'b0;
  endtask

  // Latency counts the accept edge itself as edge 1.
  task automatic wait_result(input logic [63:0] d, input int lat_lit, input int cnt_lit,
                             input logic z_lit, input logic [63:0] norm_lit);
    int lat = 1;
    while (!out_valid && lat <= 20) begin
      @(posedge CLK);
      lat++;
      @(negedge CLK);
    end
    check("latency_model", 64'(lat), 64'(model_k(d) + 1));
    check("latency_lit",   64'(lat), 64'(lat_lit));
    check("count_lit",     64'(out_count), 64'(cnt_lit));
    check("zero_lit",      64'(out_zero),  64'(z_lit));
    check("norm_lit",      out_norm,       norm_lit);
  endtask

  task automatic handshake();
    out_ready = 1'b1;
    @(posedge CLK);
    @(negedge CLK);
    out_ready = 1'b0;
    check("post_hs_valid", 64'(out_valid), 64'd0);
    check("post_hs_ready", 64'(in_ready),  64'd1);
  endtask

  initial begin
    RESET_n   = 1'b0;
    abort     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    #12;
    check_reset_outputs("rst");
    @(negedge CLK);
    RESET_n = 1'b1;
    @(negedge CLK);
    check_reset_outputs("post_rst");

    accept(64'h8000_0000_0000_0000);
    wait_result(64'h8000_0000_0000_0000, 2, 0, 1'b0, 64'h8000_0000_0000_0000);
    handshake();

    accept(64'h0000_0000_0000_0001);
    wait_result(64'h0000_0000_0000_0001, 9, 63, 1'b0, 64'h8000_0000_0000_0000);
    handshake();

    accept(64'h0);
    wait_result(64'h0, 9, 64, 1'b1, 64'h0);
    handshake();

    accept(64'h0000_0010_0000_0000);
    wait_result(64'h0000_0010_0000_0000, 5, 27, 1'b0, 64'h8000_0000_0000_0000);
    handshake();

    accept(64'h007F_0000_0000_0000);
    wait_result(64'h007F_0000_0000_0000, 3, 9, 1'b0, 64'hFE00_0000_0000_0000);
    handshake();

    // Backpressure with a second operand waiting
    accept(64'h0000_0000_00F0_1234);
    wait_result(64'h0000_0000_00F0_1234, 7, 40, 1'b0, 64'hF012_3400_0000_0000);
    in_valid = 1'b1;
    in_data  = 64'h0123_4567_89AB_CDEF;
    repeat (5) begin
      @(posedge CLK);
      @(negedge CLK);
      check("bp_in_ready",  64'(in_ready),  64'd0);
      check("bp_out_valid", 64'(out_valid), 64'd1);
      check("bp_count",     64'(out_count), 64'd40);
      check("bp_norm",      out_norm,       64'hF012_3400_0000_0000);
    end
    out_ready = 1'b1;
    @(posedge CLK);
    @(negedge CLK);
    out_ready = 1'b0;
    check("bp_gap_ready", 64'(in_ready),  64'd1);
    check("bp_gap_valid", 64'(out_valid), 64'd0);
    @(posedge CLK);
    @(negedge CLK);
    in_valid = 1'b0;
    check("bp_second_busy", 64'(busy), 64'd1);
    wait_result(64'h0123_4567_89AB_CDEF, 2, 7, 1'b0, 64'h91A2_B3C4_D5E6_F780);
    handshake();

    // Abort while scanning byte 3 of a zero operand
    accept(64'h0);
    repeat (3) begin
      @(posedge CLK);
      @(negedge CLK);
    end
    abort = 1'b1;
    @(posedge CLK);
    @(negedge CLK);
    abort = 1'b0;
    check_reset_outputs("abort");
    repeat (12) begin
      @(negedge CLK);
      check("abort_no_valid", 64'(out_valid), 64'd0);
    end

    // Abort in IDLE overrides a concurrent offer
    @(negedge CLK);
    abort    = 1'b1;
    in_valid = 1'b1;
    in_data  = 64'h1;
    @(posedge CLK);
    @(negedge CLK);
    abort    = 1'b0;
    in_valid = 1'b0;
    check("abort_idle_busy",  64'(busy),     64'd0);
    check("abort_idle_ready", 64'(in_ready), 64'd1);

    // Asynchronous reset in the middle of a scan
    accept(64'h0);
    @(posedge CLK);
    #2;
    RESET_n = 1'b0;
    #1;
    check_reset_outputs("mid_rst");
    @(negedge CLK);
    check_reset_outputs("mid_rst_hold");
    RESET_n = 1'b1;
    @(negedge CLK);
    check("rst_recover_ready", 64'(in_ready), 64'd1);

    accept(64'h0000_0100_0000_0000);
    wait_result(64'h0000_0100_0000_0000, 4, 23, 1'b0, 64'h8000_0000_0000_0000);
    handshake();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation exceeded time limit at %0t", $time);
    $fatal(1, "timeout");
  end

endmodule
